alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised two-stage pipelined ALU for the processor datapath. It generalises the combinational single-cycle ALU in four ways:
- configurable data width and immediate width;
- a valid/ready handshake with backpressure on both sides;
- a registered N/Z/V flag file with per-opcode update rules;
- an explicit illegal-opcode error output.

It sits between the decode/register-read stage and the writeback/memory stage.

## Interface
- WIDTH, 16, data width; multiple of 8, at least 16
- IMM_W, 4, immediate width; at most WIDTH-1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  ALU accepts an operation this cycle
- in_opcode  in  4  operation select
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_imm  in  IMM_W  signed immediate
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_err  out  1  result came from an illegal opcode
- flags  out  3  {N, Z, V} flag register

## Operation
- Opcodes:
  - 0 ADD, saturating signed
  - 1 SUB, saturating signed: A + ~B + 1
  - 2 RED
  - 3 XOR
  - 4 SLL
  - 5 SRA
  - 6 ROR
  - 7 PADDSB
  - 8 LW-address
  - 9 SW-address
  - 10-15 illegal
- ADD and SUB saturation:
  - Signed overflow with a non-negative true result gives 0x7F..F.
  - Signed overflow with a negative true result gives 0x80..0.
  - V is the raw signed overflow.
- RED: signed sum of all WIDTH/8 bytes of A and all WIDTH/8 bytes of B. Computed at full precision, sign-extended to WIDTH, no saturation.
- XOR: A ^ B.
- Shifts and rotate use amount = B[$clog2(WIDTH)-1:0].
  - SLL fills with zeros.
  - SRA replicates the sign bit.
  - ROR rotates right.
  - Amount 0 passes A through unchanged.
- PADDSB: independent signed 4-bit lanes, WIDTH/4 of them. Each lane saturates to 0x7 or 0x8. No carry crosses lanes.
- LW/SW address: A + (sign_extend(imm) << 1), modulo 2^WIDTH, no saturation.
- Illegal opcodes:
  - out_result = 0 and out_err = 1.
  - Flags are unchanged.
  - The result still flows through the handshake.
- Flag update rules, applied when the operation enters stage 2:
  - ADD and SUB write N, Z and V, all taken from the saturated result except V.
  - XOR, SLL, SRA and ROR write Z only.
  - RED, PADDSB, LW, SW and illegal opcodes write nothing.
- Pipeline:
  - Stage 1 registers the opcode, operands and immediate.
  - Stage 2 computes the result and registers result, err and flags.
  - Results are returned in issue order. None are dropped or duplicated.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_result = 0, out_err = 0, flags = 3'b000. Both stage-valid bits are cleared.
- An operation is accepted on a rising edge where in_valid && in_ready.
- Latency: out_valid rises 2 edges after acceptance when there is no stall. Throughput is 1 operation per cycle.
- in_ready = !s1_valid || !s2_valid || out_ready. This is combinational from out_ready.
- Stall (out_valid && !out_ready):
  - Stage 2 holds out_result, out_err and flags stable.
  - Stage 1 holds if occupied.
  - At most 2 operations are in flight.
- A simultaneous drain at stage 2, stage 1 advance and new accept in one cycle is legal and must not lose data.
- The flags output changes on the same edge that the producing result is loaded into stage 2, so flags are aligned with out_valid for that result.
- rst_n asserted mid-operation discards everything in flight immediately. There is no partial result.
- in_* inputs are ignored when in_valid = 0.

## Configuration
- ALU_PIPE_RED_EN.
  - Defined: opcode 2 performs RED as specified.
  - Undefined: the RED adder tree is omitted and opcode 2 is treated as illegal: result 0, out_err = 1, flags unchanged.

## Test plan
- ADD with A = 0x7FFF, B = 0x0001 -> out_result = 0x7FFF, flags {N,Z,V} = 001. SUB with A = 0x8000, B = 0x0001 -> 0x8000, flags = 101.
- PADDSB with A = 0x7801, B = 0x1F01 -> 0x7802, flags unchanged from the prior value.
- SRA with A = 0x8001, B = 0x0001 -> 0xC000, Z = 0, N and V retained. ROR with A = 0x0001, B = 0x0004 -> 0x1000.
- LW with A = 0x1000, imm = 0xE -> 0x0FFC.
- RED with A = 0x0102, B = 0x03FF:
  - ALU_PIPE_RED_EN defined -> 0x0005.
  - Undefined -> 0x0000 with out_err = 1.
- Backpressure and reset:
  - Hold out_ready = 0 and issue 3 back-to-back ADDs. in_ready drops after 2 accepts. Releasing out_ready returns the results in order.
  - Pulse rst_n low with 2 operations in flight -> out_valid = 0 and flags = 000 immediately. No stale result appears afterwards.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation/result handshake bundle between decode/register-read and writeback.
// master drives operations and consumes results; slave is the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [IMM_W-1:0] in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  logic [2:0]       flags;

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_imm, out_ready,
    input  in_ready, out_valid, out_result, out_err, flags
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_imm, out_ready,
    output in_ready, out_valid, out_result, out_err, flags
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready backpressure and a registered {N,Z,V} flag file.
// Define ALU_PIPE_RED_EN to build the byte-reduction opcode; otherwise opcode 2 is illegal.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_RED = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRA = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_PAD = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;

  logic                    vld_p1;
  logic [3:0]              op_p1;
  logic signed [WIDTH-1:0] a_p1;
  logic signed [WIDTH-1:0] b_p1;
  logic [IMM_W-1:0]        imm_p1;

  logic                    vld_p2;
  logic signed [WIDTH-1:0] result_p2;
  logic                    err_p2;
  logic [2:0]              flags_p2;

  logic take;
  logic adv;

  // Returns {overflow, saturated result}; SUB is A + ~B + 1 in WIDTH+1 bits.
  function automatic logic [WIDTH:0] sat_addsub(input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b,
                                                input logic sub);
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   bx;
    logic             ovf;
    logic [WIDTH-1:0] r;
    bx  = sub ? ~{b[WIDTH-1], b} : {b[WIDTH-1], b};
    t   = {a[WIDTH-1], a} + bx + (WIDTH+1)'(sub);
    ovf = t[WIDTH] ^ t[WIDTH-1];
    if (ovf) r = t[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else     r = t[WIDTH-1:0];
    return {ovf, r};
  endfunction

  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] t;
    t = {a[3], a} + {b[3], b};
    if (t[4] != t[3]) return t[4] ? 4'h8 : 4'h7;
    return t[3:0];
  endfunction

`ifdef ALU_PIPE_RED_EN
  function automatic logic [WIDTH-1:0] red_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH / 8; i++) begin
      s = s + WIDTH'($signed(a[8*i +: 8])) + WIDTH'($signed(b[8*i +: 8]));
    end
    return s;
  endfunction
`endif

  assign bus.in_ready = !vld_p1 || !vld_p2 || bus.out_ready;
  assign take         = bus.in_valid && bus.in_ready;
  assign adv          = vld_p1 && (!vld_p2 || bus.out_ready);

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (take) begin
      op_p1  <= bus.in_opcode;
      a_p1   <= bus.in_a;
      b_p1   <= bus.in_b;
      imm_p1 <= bus.in_imm;
    end
  end

  logic signed [WIDTH-1:0] res_c;
  logic                    err_c;
  logic [2:0]              flags_c;
  logic [WIDTH:0]          as_c;
  logic [SHW-1:0]          amt;
  logic signed [WIDTH-1:0] immx;
  logic [WIDTH-1:0]        ua;

  always_comb begin
    res_c   = '0;
    err_c   = 1'b0;
    flags_c = flags_p2;
    as_c    = sat_addsub(a_p1, b_p1, op_p1 == OP_SUB);
    amt     = b_p1[SHW-1:0];
    immx    = {{(WIDTH-IMM_W){imm_p1[IMM_W-1]}}, imm_p1};
    ua      = a_p1;
    case (op_p1)
      OP_ADD, OP_SUB: begin
        res_c   = as_c[WIDTH-1:0];
        flags_c = {as_c[WIDTH-1], as_c[WIDTH-1:0] == '0, as_c[WIDTH]};
      end
`ifdef ALU_PIPE_RED_EN
      OP_RED: res_c = red_sum(a_p1, b_p1);
`endif
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
        case (op_p1)
          OP_XOR:  res_c = a_p1 ^ b_p1;
          OP_SLL:  res_c = a_p1 << amt;
          OP_SRA:  res_c = a_p1 >>> amt;
          default: res_c = (ua >> amt) | (ua << (WIDTH - int'(amt)));
        endcase
        flags_c = {flags_p2[2], res_c == '0, flags_p2[0]};
      end
      OP_PAD: begin
        for (int l = 0; l < WIDTH / 4; l++) begin
          res_c[4*l +: 4] = sat_add4(a_p1[4*l +: 4], b_p1[4*l +: 4]);
        end
      end
      OP_LW, OP_SW: res_c = a_p1 + (immx <<< 1);
      default: err_c = 1'b1;
    endcase
  end

  // ---- stage 2: result, error and flag registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      err_p2    <= 1'b0;
      flags_p2  <= 3'b000;
    end else begin
      vld_p1 <= take || (vld_p1 && !adv);
      vld_p2 <= adv || (vld_p2 && !bus.out_ready);
      if (adv) begin
        result_p2 <= res_c;
        err_p2    <= err_c;
        flags_p2  <= flags_c;
      end
    end
  end

  assign bus.out_valid  = vld_p2;
  assign bus.out_result = result_p2;
  assign bus.out_err    = err_p2;
  assign bus.flags      = flags_p2;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W  = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W), .IMM_W(IW)) ifc ();

  alu_pipe #(.WIDTH(W), .IMM_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    logic [15:0] r;
    logic        e;
    logic [2:0]  f;
  } exp_t;

  exp_t       q[$];
  logic [2:0] mflags = 3'b000;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] imm, input logic [2:0] fl);
    exp_t x;
    int sa, sb, t, amt, la, lb;
    logic v;
    logic [15:0] r;
    x.e = 1'b0; x.f = fl; r = '0; v = 1'b0;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    amt = int'(b[3:0]);
    case (op)
      0, 1: begin
        t = (op == 0) ? sa + sb : sa - sb;
        if (t > 32767)       begin r = 16'h7FFF; v = 1'b1; end
        else if (t < -32768) begin r = 16'h8000; v = 1'b1; end
        else                 r = t[15:0];
        x.f = {r[15], r == 16'h0, v};
      end
      2: begin
`ifdef ALU_PIPE_RED_EN
        t = 0;
        for (int i = 0; i < 2; i++) t += int'($signed(a[8*i +: 8])) + int'($signed(b[8*i +: 8]));
        r = t[15:0];
`else
        x.e = 1'b1;
`endif
      end
      3: begin r = a ^ b; x.f[1] = (r == 16'h0); end
      4: begin r = a << amt; x.f[1] = (r == 16'h0); end
      5: begin t = sa >>> amt; r = t[15:0]; x.f[1] = (r == 16'h0); end
      6: begin
        r = a;
        for (int i = 0; i < amt; i++) r = {r[0], r[15:1]};
        x.f[1] = (r == 16'h0);
      end
      7: begin
        for (int l = 0; l < 4; l++) begin
          la = int'($signed(a[4*l +: 4]));
          lb = int'($signed(b[4*l +: 4]));
          t  = la + lb;
          if (t > 7) t = 7;
          if (t < -8) t = -8;
          r[4*l +: 4] = t[3:0];
        end
      end
      8, 9: begin t = int'(a) + 2 * int'($signed(imm)); r = t[15:0]; end
      default: x.e = 1'b1;
    endcase
    x.r = r;
    return x;
  endfunction

  // Result scoreboard: every transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (q.size() == 0) chk("stale_output", {31'b0, ifc.out_valid}, 32'd0);
      else begin
        e = q.pop_front();
        chk("sb_result", {16'b0, ifc.out_result}, {16'b0, e.r});
        chk("sb_err", {31'b0, ifc.out_err}, {31'b0, e.e});
        chk("sb_flags", {29'b0, ifc.flags}, {29'b0, e.f});
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the operation.
  task automatic send(input int op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] imm, input bit rnd_ready);
    bit done = 1'b0;
    ifc.in_valid = 1'b1; ifc.in_opcode = op[3:0]; ifc.in_a = a; ifc.in_b = b; ifc.in_imm = imm;
    for (int c = 0; c < 64 && !done; c++) begin
      if (rnd_ready) ifc.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (ifc.in_ready) begin
        q.push_back(model(op, a, b, imm, mflags));
        mflags = q[$].f;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    chk("accept_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic directed(input string tag, input int op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] imm, input logic [15:0] er, input logic ee, input logic [2:0] ef);
    bit seen = 1'b0;
    send(op, a, b, imm, 1'b0);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (ifc.out_valid) seen = 1'b1;
    end
    chk({tag, "_valid"}, {31'b0, seen}, 32'd1);
    chk({tag, "_res"}, {16'b0, ifc.out_result}, {16'b0, er});
    chk({tag, "_err"}, {31'b0, ifc.out_err}, {31'b0, ee});
    chk({tag, "_flags"}, {29'b0, ifc.flags}, {29'b0, ef});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    ifc.out_ready = 1'b1;
    for (int c = 0; c < 100 && q.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    int rop;
    ifc.in_valid = 1'b0; ifc.in_opcode = '0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_imm = '0;
    ifc.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, ifc.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("rst_out_result", {16'b0, ifc.out_result}, 32'd0);
    chk("rst_out_err", {31'b0, ifc.out_err}, 32'd0);
    chk("rst_flags", {29'b0, ifc.flags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed("add_sat", 0, 16'h7FFF, 16'h0001, 4'h0, 16'h7FFF, 1'b0, 3'b001);
    directed("sub_sat", 1, 16'h8000, 16'h0001, 4'h0, 16'h8000, 1'b0, 3'b101);
    directed("paddsb", 7, 16'h7801, 16'h1F01, 4'h0, 16'h7802, 1'b0, 3'b101);
    directed("sra", 5, 16'h8001, 16'h0001, 4'h0, 16'hC000, 1'b0, 3'b101);
    directed("ror", 6, 16'h0001, 16'h0004, 4'h0, 16'h1000, 1'b0, 3'b101);
    directed("lw", 8, 16'h1000, 16'h0000, 4'hE, 16'h0FFC, 1'b0, 3'b101);
    directed("sw_wrap", 9, 16'hFFFF, 16'h1234, 4'h1, 16'h0001, 1'b0, 3'b101);
`ifdef ALU_PIPE_RED_EN
    directed("red", 2, 16'h0102, 16'h03FF, 4'h0, 16'h0005, 1'b0, 3'b101);
`else
    directed("red_off", 2, 16'h0102, 16'h03FF, 4'h0, 16'h0000, 1'b1, 3'b101);
`endif
    directed("illegal", 12, 16'hABCD, 16'h1234, 4'h3, 16'h0000, 1'b1, 3'b101);
    directed("xor_zero", 3, 16'h1234, 16'h1234, 4'h0, 16'h0000, 1'b0, 3'b111);
    directed("sll", 4, 16'h0001, 16'h000F, 4'h0, 16'h8000, 1'b0, 3'b101);
    directed("sra_amt0", 5, 16'h8001, 16'h0010, 4'h0, 16'h8001, 1'b0, 3'b101);
    directed("add_zero", 0, 16'h0000, 16'h0000, 4'h0, 16'h0000, 1'b0, 3'b010);
    directed("add_negsat", 0, 16'h8000, 16'h8000, 4'h0, 16'h8000, 1'b0, 3'b101);

    send(3, 16'h00F0, 16'h0F00, 4'h0, 1'b0);
    @(negedge clk);
    chk("lat_edge1", {31'b0, ifc.out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_edge2", {31'b0, ifc.out_valid}, 32'd1);
    @(posedge clk); #1;
    drain();

    // Backpressure: two accepts fill the pipe, the third waits for out_ready.
    ifc.out_ready = 1'b0;
    send(0, 16'h0100, 16'h0001, 4'h0, 1'b0);
    send(0, 16'h0200, 16'h0002, 4'h0, 1'b0);
    ifc.in_valid = 1'b1; ifc.in_opcode = 4'd0; ifc.in_a = 16'h0300; ifc.in_b = 16'h0003;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, ifc.in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, ifc.out_valid}, 32'd1);
      chk("bp_hold_res", {16'b0, ifc.out_result}, 32'h0101);
      @(posedge clk); #1;
    end
    ifc.out_ready = 1'b1;
    send(0, 16'h0300, 16'h0003, 4'h0, 1'b0);
    drain();

    // Reset with two operations in flight.
    ifc.out_ready = 1'b0;
    send(0, 16'h7FFF, 16'h0001, 4'h0, 1'b0);
    send(1, 16'h8000, 16'h0001, 4'h0, 1'b0);
    @(negedge clk);
    chk("prerst_valid", {31'b0, ifc.out_valid}, 32'd1);
    chk("prerst_flags", {29'b0, ifc.flags}, 32'b001);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("midrst_flags", {29'b0, ifc.flags}, 32'd0);
    chk("midrst_result", {16'b0, ifc.out_result}, 32'd0);
    chk("midrst_in_ready", {31'b0, ifc.in_ready}, 32'd1);
    q.delete();
    mflags = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_stale", {31'b0, ifc.out_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random gaps and random backpressure.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        ifc.out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      rop = $urandom_range(0, 15);
      ra  = $urandom_range(0, 3) == 0 ? (($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000) : 16'($urandom);
      rb  = $urandom_range(0, 3) == 0 ? (($urandom_range(0, 1) == 0) ? 16'h0001 : 16'hFFFF) : 16'($urandom);
      send(rop, ra, rb, 4'($urandom), 1'b1);
    end
    drain();
    @(negedge clk);
    chk("final_idle", {31'b0, ifc.out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
